// File: rtl/output_arbiter.sv
// Round-robin, packet-locked arbiter for one router output port.
// Latency: req in IDLE -> grant/busy next cycle; tail transfer hands off with no bubble.
// Backpressure: out_ready=0 or an owner underrun freezes the lock; buffers pop only on transfer.
module output_arbiter #(
  parameter int N_PORTS = 5,
  parameter int SEL_W   = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_PORTS-1:0] req,
  input  logic [N_PORTS-1:0] tail,
  input  logic               out_ready,
  output logic [N_PORTS-1:0] grant,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  output logic [N_PORTS-1:0] buf_read,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  // After reset the last winner is the highest port, so port 0 is searched first.
  localparam logic [SEL_W-1:0] PTR_RST = SEL_W'(N_PORTS - 1);

  state_e             state_q;
  logic [N_PORTS-1:0] grant_q;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   ptr_q;

  logic               owner_req;
  logic               owner_tail;
  logic               xfer;
  logic               arb_found;
  logic [SEL_W-1:0]   arb_idx;

  // Owner-side view of the request and tail lines; non-owner bits are masked off.
  assign owner_req  = |(req & grant_q);
  assign owner_tail = |(tail & grant_q);

  // Flit presented and accepted; tail deliberately plays no part in the pop strobe.
  assign out_valid = (state_q == ST_LOCKED) & owner_req;
  assign xfer      = out_valid & out_ready;
  assign buf_read  = grant_q & {N_PORTS{xfer}};

  assign grant   = grant_q;
  assign out_sel = sel_q;
  assign busy    = (state_q == ST_LOCKED);

  // Round-robin search starting just after the last winner, ending on the last winner itself.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      if (!arb_found && req[(int'(ptr_q) + k) % N_PORTS]) begin
        arb_found = 1'b1;
        arb_idx   = SEL_W'((int'(ptr_q) + k) % N_PORTS);
      end
    end
  end

  // Lock FSM: grant on request in IDLE, hold until the owner's tail transfers, then re-arbitrate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            state_q <= ST_LOCKED;
            grant_q <= N_PORTS'(1) << arb_idx;
            sel_q   <= arb_idx;
            ptr_q   <= arb_idx;
          end
        end
        ST_LOCKED: begin
          // ptr_q equals the owner here, so the search naturally puts the owner last.
          if (xfer && owner_tail) begin
            if (arb_found) begin
              grant_q <= N_PORTS'(1) << arb_idx;
              sel_q   <= arb_idx;
              ptr_q   <= arb_idx;
            end else begin
              state_q <= ST_IDLE;
              grant_q <= '0;
              sel_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          sel_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter: reset, single packet, rotation, lock, stalls, wrap, async reset.
// Inputs change 1ns after the rising edge; outputs are compared 2ns after it.
// Each scenario starts from a fresh reset so the pointer starts at port 4.
module tb_output_arbiter;

  logic       clk;
  logic       reset;
  logic [4:0] req;
  logic [4:0] tail;
  logic       out_ready;
  logic [4:0] grant;
  logic [2:0] out_sel;
  logic       out_valid;
  logic [4:0] buf_read;
  logic       busy;

  int n_cmp;
  int n_err;

  output_arbiter #(.N_PORTS(5), .SEL_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .tail      (tail),
    .out_ready (out_ready),
    .grant     (grant),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .buf_read  (buf_read),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply inputs for the current cycle and let combinational outputs settle.
  task automatic drive(input logic [4:0] r, input logic [4:0] t, input logic rdy);
    req       = r;
    tail      = t;
    out_ready = rdy;
    #1;
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req       = '0;
    tail      = '0;
    out_ready = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Compare the full registered/combinational output set.
  task automatic check_all(input string tag, input logic [4:0] g, input logic [2:0] s,
                           input logic b, input logic v, input logic [4:0] rd);
    check({tag, ".grant"},    32'(grant),     32'(g));
    check({tag, ".out_sel"},  32'(out_sel),   32'(s));
    check({tag, ".busy"},     32'(busy),      32'(b));
    check({tag, ".out_valid"},32'(out_valid), 32'(v));
    check({tag, ".buf_read"}, 32'(buf_read),  32'(rd));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;

    // ---------------- Reset then single packet on port 2 ----------------
    do_reset();
    drive(5'b00000, 5'b00000, 1'b1);
    check_all("rst_idle", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);
    next_cycle();
    drive(5'b00000, 5'b00000, 1'b1);
    check_all("idle_noreq", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);
    drive(5'b00100, 5'b00000, 1'b1);
    check("p2_req_cycle.buf_read", 32'(buf_read), 32'h0);
    next_cycle();
    drive(5'b00100, 5'b00000, 1'b1);
    check_all("p2_f1", 5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100);
    next_cycle();
    drive(5'b00100, 5'b00000, 1'b1);
    check_all("p2_f2", 5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100);
    next_cycle();
    drive(5'b00100, 5'b00100, 1'b1);
    check_all("p2_f3_tail", 5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100);
    next_cycle();
    // Port 2's request was still up during its tail, so as sole requester it keeps the output;
    // with its buffer now empty it is an underrun: grant held, nothing popped.
    drive(5'b00000, 5'b00000, 1'b1);
    check_all("p2_after_tail", 5'b00100, 3'd2, 1'b1, 1'b0, 5'b00000);

    // ---------------- Fairness rotation, single-flit packets ----------------
    do_reset();
    drive(5'b11111, 5'b11111, 1'b1);
    check("rr_idle.busy", 32'(busy), 32'h0);
    for (int i = 0; i < 6; i++) begin
      next_cycle();
      drive(5'b11111, 5'b11111, 1'b1);
      check($sformatf("rr%0d.grant", i), 32'(grant), 32'(5'b00001 << (i % 5)));
      check($sformatf("rr%0d.sel", i), 32'(out_sel), 32'(i % 5));
      check($sformatf("rr%0d.buf_read", i), 32'(buf_read), 32'(5'b00001 << (i % 5)));
    end

    // ---------------- Packet lock: port 1 4-flit, port 3 arrives mid-packet ----------------
    do_reset();
    drive(5'b00010, 5'b00000, 1'b1);
    next_cycle();
    drive(5'b00010, 5'b00000, 1'b1);
    check_all("lk_f1", 5'b00010, 3'd1, 1'b1, 1'b1, 5'b00010);
    next_cycle();
    drive(5'b01010, 5'b00000, 1'b1);
    check_all("lk_f2", 5'b00010, 3'd1, 1'b1, 1'b1, 5'b00010);
    next_cycle();
    drive(5'b01010, 5'b01000, 1'b1);  // non-owner tail must be ignored
    check_all("lk_f3", 5'b00010, 3'd1, 1'b1, 1'b1, 5'b00010);
    next_cycle();
    drive(5'b01010, 5'b00010, 1'b1);
    check_all("lk_f4_tail", 5'b00010, 3'd1, 1'b1, 1'b1, 5'b00010);
    next_cycle();
    drive(5'b01000, 5'b00000, 1'b1);
    check_all("lk_handoff", 5'b01000, 3'd3, 1'b1, 1'b1, 5'b01000);

    // ---------------- Backpressure and underrun: owner 0, port 2 waiting ----------------
    do_reset();
    drive(5'b00101, 5'b00000, 1'b1);
    next_cycle();
    drive(5'b00101, 5'b00000, 1'b1);
    check_all("bp_f1", 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(5'b00101, 5'b00101, 1'b0);
      check_all($sformatf("bp_stall%0d", i), 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00000);
    end
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(5'b00100, 5'b00100, 1'b1);
      check_all($sformatf("bp_under%0d", i), 5'b00001, 3'd0, 1'b1, 1'b0, 5'b00000);
    end
    next_cycle();
    drive(5'b00101, 5'b00001, 1'b1);
    check_all("bp_tail", 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001);
    next_cycle();
    drive(5'b00100, 5'b00100, 1'b1);
    check_all("bp_next", 5'b00100, 3'd2, 1'b1, 1'b1, 5'b00100);

    // ---------------- Sole requester repeat on port 4, then wrap to port 0 ----------------
    do_reset();
    drive(5'b10000, 5'b00000, 1'b1);
    next_cycle();
    drive(5'b10000, 5'b00000, 1'b1);
    check_all("wr_a1", 5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000);
    next_cycle();
    drive(5'b10000, 5'b10000, 1'b1);
    check_all("wr_a2_tail", 5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000);
    next_cycle();
    drive(5'b10001, 5'b10000, 1'b1);
    check_all("wr_b1_tail", 5'b10000, 3'd4, 1'b1, 1'b1, 5'b10000);
    next_cycle();
    drive(5'b00001, 5'b00001, 1'b1);
    check_all("wr_wrap", 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001);

    // ---------------- Reset mid-packet on port 3 ----------------
    do_reset();
    drive(5'b01000, 5'b00000, 1'b1);
    next_cycle();
    drive(5'b01000, 5'b00000, 1'b1);
    check_all("mr_f1", 5'b01000, 3'd3, 1'b1, 1'b1, 5'b01000);
    next_cycle();
    drive(5'b01000, 5'b00000, 1'b1);
    check("mr_f2.grant", 32'(grant), 32'(5'b01000));
    reset = 1'b0;
    #1;
    check_all("mr_async", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);
    next_cycle();
    drive(5'b01001, 5'b00000, 1'b1);
    check_all("mr_held", 5'b00000, 3'd0, 1'b0, 1'b0, 5'b00000);
    reset = 1'b1;
    next_cycle();
    drive(5'b01001, 5'b00000, 1'b1);
    check_all("mr_rearb", 5'b00001, 3'd0, 1'b1, 1'b1, 5'b00001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
